// File: rtl/biriscv_branch_resolve.sv
// Branch resolution and predictor-update sequencer: registered fetch redirect plus
// an in-order update queue feeding the single-port predictor. Optional counters: BRANCH_RESOLVE_STATS_EN.
module biriscv_branch_resolve #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p0_valid_i,
  input  logic [31:0] p0_pc_i,
  input  logic        p0_taken_i,
  input  logic [31:0] p0_target_i,
  input  logic        p0_is_call_i,
  input  logic        p0_is_ret_i,
  input  logic        p0_is_jmp_i,
  input  logic        p0_pred_taken_i,
  input  logic [31:0] p0_pred_target_i,
  input  logic        p1_valid_i,
  input  logic [31:0] p1_pc_i,
  input  logic        p1_taken_i,
  input  logic [31:0] p1_target_i,
  input  logic        p1_is_call_i,
  input  logic        p1_is_ret_i,
  input  logic        p1_is_jmp_i,
  input  logic        p1_pred_taken_i,
  input  logic [31:0] p1_pred_target_i,
  output logic        flush_o,
  output logic [31:0] flush_pc_o,
  output logic        stall_o,
  output logic        overflow_o,
  output logic        branch_request_o,
  output logic        branch_is_taken_o,
  output logic        branch_is_not_taken_o,
  output logic [31:0] branch_source_o,
  output logic [31:0] branch_pc_o,
  output logic        branch_is_call_o,
  output logic        branch_is_ret_o,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispredicts_o,
`endif
  output logic        branch_is_jmp_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        call;
    logic        ret;
    logic        jmp;
    logic        mis;
  } rec_t;

  localparam logic [DEPTH_W:0] ZERO     = (DEPTH_W+1)'(0);
  localparam logic [DEPTH_W:0] ONE      = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W:0] TWO      = (DEPTH_W+1)'(2);
  localparam logic [DEPTH_W:0] DEPTH_C  = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] STALL_TH = (DEPTH_W+1)'(DEPTH - 2);

  rec_t               mem_r [DEPTH];
  rec_t               head_r;
  logic               head_valid_r;
  logic [DEPTH_W:0]   count_r;
  logic [DEPTH_W-1:0] rd_ptr_r;
  logic [DEPTH_W-1:0] wr_ptr_r;
  logic               flush_r;
  logic [31:0]        flush_pc_r;
  logic               overflow_r;

  logic               mis0_s, v1_s, mis1_s, pop_q_s, bypass_s, drop_s, src_valid_s;
  rec_t               rec0_s, rec1_s, in_a_s, in_b_s, src_s, enq_a_s, enq_b_s;
  logic [DEPTH_W:0]   n_in_s, n_enq_s, n_acc_s, space_s;
  logic [31:0]        flush_pc_s;
  logic [DEPTH_W-1:0] wr_ptr1_s;

  // Mispredict detection, pipe 1 squash and flush target selection
  always_comb begin
    mis0_s = p0_valid_i & ((p0_taken_i != p0_pred_taken_i) |
                           (p0_taken_i & (p0_target_i != p0_pred_target_i)));
    v1_s   = p1_valid_i & ~mis0_s;
    mis1_s = v1_s & ((p1_taken_i != p1_pred_taken_i) |
                     (p1_taken_i & (p1_target_i != p1_pred_target_i)));
    rec0_s = '{pc: p0_pc_i, target: p0_target_i, taken: p0_taken_i, call: p0_is_call_i,
               ret: p0_is_ret_i, jmp: p0_is_jmp_i, mis: mis0_s};
    rec1_s = '{pc: p1_pc_i, target: p1_target_i, taken: p1_taken_i, call: p1_is_call_i,
               ret: p1_is_ret_i, jmp: p1_is_jmp_i, mis: mis1_s};
    if (mis0_s) begin
      flush_pc_s = p0_taken_i ? p0_target_i : p0_pc_i + 32'd4;
    end else if (mis1_s) begin
      flush_pc_s = p1_taken_i ? p1_target_i : p1_pc_i + 32'd4;
    end else begin
      flush_pc_s = 32'd0;
    end
  end

  // Order incoming records, pick the head source (queue or fall-through) and admit what fits
  always_comb begin
    in_a_s      = '0;
    in_b_s      = '0;
    n_in_s      = ZERO;
    src_s       = '0;
    src_valid_s = 1'b0;
    enq_a_s     = '0;
    enq_b_s     = '0;
    n_enq_s     = ZERO;
    bypass_s    = 1'b0;
    pop_q_s     = (count_r != ZERO);
    if (p0_valid_i) begin
      in_a_s = rec0_s;
      in_b_s = rec1_s;
      n_in_s = v1_s ? TWO : ONE;
    end else if (v1_s) begin
      in_a_s = rec1_s;
      n_in_s = ONE;
    end else begin
      n_in_s = ZERO;
    end
    if (pop_q_s) begin
      src_s       = mem_r[rd_ptr_r];
      src_valid_s = 1'b1;
      enq_a_s     = in_a_s;
      enq_b_s     = in_b_s;
      n_enq_s     = n_in_s;
    end else if (n_in_s != ZERO) begin
      src_s       = in_a_s;
      src_valid_s = 1'b1;
      bypass_s    = 1'b1;
      enq_a_s     = in_b_s;
      n_enq_s     = n_in_s - ONE;
    end else begin
      src_valid_s = 1'b0;
    end
    // A pop frees its slot in the same cycle, so 2-in/1-out on a full-minus-one queue fits
    space_s = DEPTH_C - count_r + (pop_q_s ? ONE : ZERO);
    if (n_enq_s > space_s) begin
      n_acc_s = space_s;
      drop_s  = 1'b1;
    end else begin
      n_acc_s = n_enq_s;
      drop_s  = 1'b0;
    end
    wr_ptr1_s = wr_ptr_r + DEPTH_W'(1);
  end

  // Queue storage writes; pipe 0 always lands in the first free slot
  always_ff @(posedge clk_i) begin
    if (rst_i && (n_acc_s != ZERO)) begin
      mem_r[wr_ptr_r] <= enq_a_s;
    end
    if (rst_i && (n_acc_s == TWO)) begin
      mem_r[wr_ptr1_s] <= enq_b_s;
    end
  end

  // Pointers, count, head register, flush and sticky overflow
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_r      <= ZERO;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      head_r       <= '0;
      head_valid_r <= 1'b0;
      flush_r      <= 1'b0;
      flush_pc_r   <= 32'd0;
      overflow_r   <= 1'b0;
    end else begin
      count_r      <= count_r - (pop_q_s ? ONE : ZERO) + n_acc_s;
      rd_ptr_r     <= rd_ptr_r + DEPTH_W'(pop_q_s);
      wr_ptr_r     <= wr_ptr_r + n_acc_s[DEPTH_W-1:0];
      head_r       <= src_s;
      head_valid_r <= src_valid_s;
      flush_r      <= mis0_s | mis1_s;
      flush_pc_r   <= flush_pc_s;
      overflow_r   <= overflow_r | drop_s;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches_r, stat_mispredicts_r;

  // Wrapping event counters
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stat_branches_r    <= 32'd0;
      stat_mispredicts_r <= 32'd0;
    end else begin
      stat_branches_r    <= stat_branches_r + 32'(n_acc_s) + 32'(bypass_s);
      stat_mispredicts_r <= stat_mispredicts_r + 32'(mis0_s | mis1_s);
    end
  end

  assign stat_branches_o    = stat_branches_r;
  assign stat_mispredicts_o = stat_mispredicts_r;
`endif

  assign flush_o               = flush_r;
  assign flush_pc_o            = flush_pc_r;
  assign stall_o               = (count_r > STALL_TH);
  assign overflow_o            = overflow_r;
  assign branch_request_o      = head_valid_r & (head_r.mis | head_r.call | head_r.ret);
  assign branch_is_taken_o     = head_valid_r & head_r.taken;
  assign branch_is_not_taken_o = head_valid_r & ~head_r.taken;
  assign branch_source_o       = head_r.pc;
  assign branch_pc_o           = head_r.target;
  assign branch_is_call_o      = head_valid_r & head_r.call;
  assign branch_is_ret_o       = head_valid_r & head_r.ret;
  assign branch_is_jmp_o       = head_valid_r & head_r.jmp;

endmodule
